// File: rtl/register_file_param.sv
`default_nettype none
// ============================================================================
//  Module   : register_file_param
//  Purpose  : 2**N x M register file, two async read ports, one sync write
//             port; top entry aliases the PC (R15). A clear sweep runs after
//             every reset with BUSY high. Optional REGFILE_BYPASS_EN macro
//             enables same-cycle write-through forwarding on both read ports.
//  Revision : 1.0  initial release
// ============================================================================
module register_file_param #(
    parameter int            N           = 4,
    parameter int            M           = 32,
    parameter logic [M-1:0]  CLEAR_VALUE = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         WE3,
    input  logic [N-1:0] A1,
    input  logic [N-1:0] A2,
    input  logic [N-1:0] A3,
    input  logic [M-1:0] WD3,
    input  logic [M-1:0] R15,
    output logic [M-1:0] RD1,
    output logic [M-1:0] RD2,
    output logic         BUSY
);

    localparam int           c_DEPTH  = 2 ** N;
    localparam logic [N-1:0] c_LAST   = N'(c_DEPTH - 1);
    localparam logic [N-1:0] c_FINAL  = N'(c_DEPTH - 2);
    localparam logic [N-1:0] c_ONE    = N'(1);

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_clr_idx;
    logic           r_busy;
    logic [M-1:0]   r_mem [c_DEPTH];

    logic           w_wr_en;

    assign w_wr_en = (r_state == S_READY) && WE3 && (A3 != c_LAST);
    assign BUSY    = r_busy;

    // Sweep sequencer: clears entries 0..DEPTH-2, the PC alias is never stored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_CLEAR;
            r_clr_idx <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (r_clr_idx == c_FINAL) begin
                        r_state <= S_READY;
                        r_busy  <= 1'b0;
                    end else begin
                        r_clr_idx <= r_clr_idx + c_ONE;
                    end
                end
                S_READY: begin
                    r_state <= S_READY;
                end
                default: begin
                    r_state   <= S_CLEAR;
                    r_clr_idx <= '0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset of its own; the sweep owns initialisation.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clr_idx] <= CLEAR_VALUE;
        end else if (w_wr_en) begin
            r_mem[A3] <= WD3;
        end
    end

    always_comb begin
        RD1 = r_mem[A1];
        RD2 = r_mem[A2];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_en && (A3 == A1)) begin
            RD1 = WD3;
        end
        if (w_wr_en && (A3 == A2)) begin
            RD2 = WD3;
        end
`endif
        if (A1 == c_LAST) begin
            RD1 = R15;
        end
        if (A2 == c_LAST) begin
            RD2 = R15;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_register_file_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_file_param
//  Purpose  : Directed self-checking bench for register_file_param (N=4, M=32).
//  Revision : 1.0  initial release
// ============================================================================
module tb_register_file_param;

    logic        clk;
    logic        reset;
    logic        we3;
    logic [3:0]  a1;
    logic [3:0]  a2;
    logic [3:0]  a3;
    logic [31:0] wd3;
    logic [31:0] r15;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        busy;

    int n_tests;
    int n_fail;

    register_file_param #(
        .N           (4),
        .M           (32),
        .CLEAR_VALUE (32'h0000_0000)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .WE3   (we3),
        .A1    (a1),
        .A2    (a2),
        .A3    (a3),
        .WD3   (wd3),
        .R15   (r15),
        .RD1   (rd1),
        .RD2   (rd2),
        .BUSY  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until BUSY drops, bounded so a stuck sweep cannot hang the run.
    task automatic wait_sweep(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 64) begin
            tick();
            cnt++;
        end
    endtask

    task automatic write_reg(input logic [3:0] addr, input logic [31:0] data);
        we3 = 1'b1;
        a3  = addr;
        wd3 = data;
        tick();
        we3 = 1'b0;
    endtask

    int cnt;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1;
        we3   = 1'b0;
        a1    = '0;
        a2    = '0;
        a3    = '0;
        wd3   = '0;
        r15   = 32'h0000_0040;

        // Clear sweep after a 3-cycle reset
        repeat (3) tick();
        check_value("busy_in_reset", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        check_value("busy_after_release", {31'd0, busy}, 32'd1);
        wait_sweep(cnt);
        check_value("sweep_len", cnt, 32'd15);
        check_value("busy_low", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            a1 = 4'(i);
            #1;
            check_value($sformatf("clear_rd1_%0d", i), rd1, 32'h0000_0000);
        end
        a1 = 4'd15;
        #1;
        check_value("pc_alias_rd1", rd1, 32'h0000_0040);

        // Write/read
        write_reg(4'd3, 32'h0F0F_0F0F);
        write_reg(4'd7, 32'hDEAD_BEEF);
        a1 = 4'd3;
        a2 = 4'd7;
        #1;
        check_value("wr_rd1_a3", rd1, 32'h0F0F_0F0F);
        check_value("wr_rd2_a7", rd2, 32'hDEAD_BEEF);
        a1 = 4'd7;
        #1;
        check_value("same_addr_rd1", rd1, 32'hDEAD_BEEF);
        check_value("same_addr_rd2", rd2, 32'hDEAD_BEEF);

        // PC protection
        r15 = 32'h0000_0100;
        we3 = 1'b1;
        a3  = 4'd15;
        wd3 = 32'h1234_5678;
        a1  = 4'd15;
        a2  = 4'd3;
        #1;
        check_value("pc_before_edge", rd1, 32'h0000_0100);
        tick();
        we3 = 1'b0;
        check_value("pc_after_edge", rd1, 32'h0000_0100);
        check_value("pc_write_no_side", rd2, 32'h0F0F_0F0F);

        // Writes during the sweep are dropped
        reset = 1'b1;
        tick();
        reset = 1'b0;
        we3 = 1'b1;
        a3  = 4'd2;
        wd3 = 32'hAAAA_AAAA;
        wait_sweep(cnt);
        we3 = 1'b0;
        check_value("sweep2_len", cnt, 32'd15);
        a1 = 4'd2;
        a2 = 4'd3;
        #1;
        check_value("busy_write_drop", rd1, 32'h0000_0000);
        check_value("old_data_cleared", rd2, 32'h0000_0000);

        // Mid-sweep reset restarts the sweep
        write_reg(4'd9, 32'h5555_5555);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (7) tick();
        check_value("busy_mid_sweep", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        check_value("busy_restart", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        wait_sweep(cnt);
        check_value("restart_len", cnt, 32'd15);
        for (int i = 0; i < 15; i++) begin
            a2 = 4'(i);
            #1;
            check_value($sformatf("restart_rd2_%0d", i), rd2, 32'h0000_0000);
        end

        // Same-cycle read of the entry being written
        write_reg(4'd5, 32'h1111_1111);
        we3 = 1'b1;
        a3  = 4'd5;
        wd3 = 32'h2222_2222;
        a1  = 4'd5;
        a2  = 4'd6;
        #1;
`ifdef REGFILE_BYPASS_EN
        check_value("bypass_rd1_pre", rd1, 32'h2222_2222);
`else
        check_value("nobypass_rd1_pre", rd1, 32'h1111_1111);
`endif
        check_value("bypass_other_port", rd2, 32'h0000_0000);
        tick();
        we3 = 1'b0;
        check_value("rd1_post_edge", rd1, 32'h2222_2222);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
